pll_lock_mon: RTL and testbench



---
 rtl/pll_lock_mon.sv | 149 ++++++++++++++
 tb/tb_pll_lock_mon.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_mon.sv
// pll_lock_mon: watches the PLL lock indicator from the system clock domain.
// It releases the PLL-domain reset only after the PLL has stayed locked for a
// stable window. It counts lock-loss events and, when enabled, pulses a PLL
// reset if lock is not achieved within a timeout.
//
// Optional feature: define PLL_AUTO_RST_EN to enable the lock timeout, the
// PLL reset pulse and retry counting. Without it, the monitor waits
// indefinitely for lock, and pll_rst and retry_cnt are tied to 0.
//
// Ports:
//   sys_clk   in   system clock, the only clock
//   sys_rst   in   synchronous active-high reset
//   locked    in   PLL lock status, asynchronous to sys_clk
//   pll_rst   out  active-high reset request to the PLL
//   rst_out   out  active-high reset for logic on PLL clocks
//   ready     out  high while the PLL is accepted as stably locked
//   loss_cnt  out  saturating count of lock losses seen in RUN
//   retry_cnt out  saturating count of PLL resets issued
module pll_lock_mon #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT   = 65536,
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             locked,
   output logic             pll_rst,
   output logic             rst_out,
   output logic             ready,
   output logic [CNT_W-1:0] loss_cnt,
   output logic [CNT_W-1:0] retry_cnt
);

   // One shared timer, sized for the longest interval it has to measure.
   localparam int unsigned TMax01 = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned TMax   = (TMax01 > PLL_RST_CYCLES) ? TMax01 : PLL_RST_CYCLES;
   localparam int unsigned TW     = $clog2(TMax) + 1;

   typedef enum logic [1:0] {
      StWaitLock  = 2'd0,
      StStableChk = 2'd1,
      StRun       = 2'd2,
      StPllReset  = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic                   rst_out_q, ready_q;
   logic [CNT_W-1:0]       loss_cnt_q;
   logic                   loss_inc;

   // Synchronizer: only the last stage is ever used.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_AUTO_RST_EN
   logic             retry_inc;
   logic             pll_rst_q;
   logic [CNT_W-1:0] retry_cnt_q;
`endif

   always_comb begin
      state_d  = state_q;
      loss_inc = 1'b0;
`ifdef PLL_AUTO_RST_EN
      retry_inc = 1'b0;
`endif
      unique case (state_q)
         StWaitLock: begin
            // Lock takes priority over a coincident timeout.
            if (locked_s) begin
               state_d = StStableChk;
            end
`ifdef PLL_AUTO_RST_EN
            else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
               state_d   = StPllReset;
               retry_inc = 1'b1;
            end
`endif
         end
         StStableChk: begin
            // A drop before release is not a loss: the PLL never counted as locked.
            if (!locked_s)                               state_d = StWaitLock;
            else if (timer_q == TW'(STABLE_CYCLES - 1))  state_d = StRun;
         end
         StRun: begin
            if (!locked_s) begin
               state_d  = StWaitLock;
               loss_inc = 1'b1;
            end
         end
`ifdef PLL_AUTO_RST_EN
         StPllReset: begin
            if (timer_q == TW'(PLL_RST_CYCLES - 1)) state_d = StWaitLock;
         end
`endif
         default: state_d = StWaitLock;
      endcase
      timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= StWaitLock;
         timer_q    <= '0;
         rst_out_q  <= 1'b1;
         ready_q    <= 1'b0;
         loss_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         rst_out_q <= (state_d != StRun);
         ready_q   <= (state_d == StRun);
         if (loss_inc && (loss_cnt_q != '1)) loss_cnt_q <= loss_cnt_q + CNT_W'(1);
      end
   end

`ifdef PLL_AUTO_RST_EN
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pll_rst_q   <= 1'b0;
         retry_cnt_q <= '0;
      end else begin
         pll_rst_q <= (state_d == StPllReset);
         if (retry_inc && (retry_cnt_q != '1)) retry_cnt_q <= retry_cnt_q + CNT_W'(1);
      end
   end

   assign pll_rst   = pll_rst_q;
   assign retry_cnt = retry_cnt_q;
`else
   assign pll_rst   = 1'b0;
   assign retry_cnt = '0;
`endif

   assign rst_out  = rst_out_q;
   assign ready    = ready_q;
   assign loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_mon.sv
module tb_pll_lock_mon;

   localparam int SS = 2;
   localparam int SC = 16;
   localparam int LT = 64;
   localparam int PR = 8;
   localparam int CW = 8;
`ifdef PLL_AUTO_RST_EN
   localparam bit Auto = 1'b1;
`else
   localparam bit Auto = 1'b0;
`endif

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          locked  = 1'b0;
   logic          pll_rst, rst_out, ready;
   logic [CW-1:0] loss_cnt, retry_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pll_lock_mon #(
      .SYNC_STAGES   (SS),
      .STABLE_CYCLES (SC),
      .LOCK_TIMEOUT  (LT),
      .PLL_RST_CYCLES(PR),
      .CNT_W         (CW)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .locked   (locked),
      .pll_rst  (pll_rst),
      .rst_out  (rst_out),
      .ready    (ready),
      .loss_cnt (loss_cnt),
      .retry_cnt(retry_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      bit rst_out;
      bit ready;
      bit pll_rst;
      int loss;
      int retry;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: 0 wait lock, 1 stable check, 2 run, 3 PLL reset.
   bit m_sync[SS];
   int m_state = 0;
   int m_timer = 0;
   int m_loss  = 0;
   int m_retry = 0;

   task automatic model_edge(input bit l, input bit r);
      int  ns;
      bit  ls;
      exp_t e;
      if (r) begin
         foreach (m_sync[i]) m_sync[i] = 1'b0;
         m_state = 0; m_timer = 0; m_loss = 0; m_retry = 0;
      end else begin
         ls = m_sync[SS-1];
         ns = m_state;
         case (m_state)
            0: if (ls) ns = 1; else if (Auto && m_timer == LT - 1) ns = 3;
            1: if (!ls) ns = 0; else if (m_timer == SC - 1) ns = 2;
            2: if (!ls) begin ns = 0; if (m_loss < 255) m_loss++; end
            default: if (m_timer == PR - 1) ns = 0;
         endcase
         if (ns == 3 && m_state != 3 && m_retry < 255) m_retry++;
         m_timer = (ns != m_state) ? 0 : m_timer + 1;
         for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = l;
         m_state   = ns;
      end
      e.rst_out = (m_state != 2);
      e.ready   = (m_state == 2);
      e.pll_rst = (m_state == 3);
      e.loss    = m_loss;
      e.retry   = m_retry;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs just after each edge against the queued expectation.
   always @(posedge sys_clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("sb_rst_out", int'(rst_out), int'(e.rst_out));
         check_eq("sb_ready", int'(ready), int'(e.ready));
         check_eq("sb_pll_rst", int'(pll_rst), int'(e.pll_rst));
         check_eq("sb_loss_cnt", int'(loss_cnt), e.loss);
         check_eq("sb_retry_cnt", int'(retry_cnt), e.retry);
      end
   end

   task automatic tick(input bit l, input bit r);
      @(negedge sys_clk);
      locked  = l;
      sys_rst = r;
      model_edge(l, r);
      @(posedge sys_clk);
      #2;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
   endtask

   initial begin
      int guard;

      // Reset state
      do_reset(3);
      check_eq("rst_rst_out", int'(rst_out), 1);
      check_eq("rst_ready", int'(ready), 0);
      check_eq("rst_pll_rst", int'(pll_rst), 0);
      check_eq("rst_loss", int'(loss_cnt), 0);

      // Lock acquisition: ready rises exactly at edge SS+SC
      for (int k = 0; k <= SS + SC; k++) begin
         tick(1'b1, 1'b0);
         if (k == SS + SC - 1) check_eq("acq_ready_early", int'(ready), 0);
         if (k == SS + SC) begin
            check_eq("acq_ready", int'(ready), 1);
            check_eq("acq_rst_out", int'(rst_out), 0);
            check_eq("acq_loss", int'(loss_cnt), 0);
         end
      end
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);

      // One-cycle lock loss from RUN
      tick(1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         tick(1'b1, 1'b0);
         if (k == 1) check_eq("loss_rst_out_early", int'(rst_out), 0);
         if (k == 2) begin
            check_eq("loss_rst_out", int'(rst_out), 1);
            check_eq("loss_cnt1", int'(loss_cnt), 1);
         end
         if (k == 18) check_eq("relock_ready_early", int'(ready), 0);
         if (k == 19) check_eq("relock_ready", int'(ready), 1);
      end

      // Drop during stable check: not a loss, full window needed afterwards
      do_reset(2);
      for (int k = 0; k < 12; k++) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      for (int k = 1; k <= 25; k++) begin
         tick(1'b1, 1'b0);
         if (k == 18) check_eq("stab_ready_early", int'(ready), 0);
         if (k == 19) check_eq("stab_ready", int'(ready), 1);
      end
      check_eq("stab_loss", int'(loss_cnt), 0);

      // Locked held low: timeout pulses, or indefinite wait without auto reset
      do_reset(2);
      if (Auto) begin
         for (int k = 1; k <= 140; k++) begin
            tick(1'b0, 1'b0);
            if (k == LT - 1) check_eq("to_pll_rst_early", int'(pll_rst), 0);
            if (k == LT) begin
               check_eq("to_pll_rst", int'(pll_rst), 1);
               check_eq("to_retry1", int'(retry_cnt), 1);
            end
            if (k == LT + PR - 1) check_eq("to_pulse_end", int'(pll_rst), 1);
            if (k == LT + PR) check_eq("to_pulse_off", int'(pll_rst), 0);
            if (k == 2 * LT + PR) begin
               check_eq("to_pll_rst2", int'(pll_rst), 1);
               check_eq("to_retry2", int'(retry_cnt), 2);
            end
         end
      end else begin
         for (int k = 1; k <= 1000; k++) tick(1'b0, 1'b0);
         check_eq("noauto_pll_rst", int'(pll_rst), 0);
         check_eq("noauto_retry", int'(retry_cnt), 0);
         check_eq("noauto_rst_out", int'(rst_out), 1);
      end

      // Lock (coincident with timeout) then 300 losses to saturate loss_cnt
      do_reset(1);
      for (int k = 1; k <= LT - 1 - SS; k++) tick(1'b0, 1'b0);
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < SS + SC + 1; k++) tick(1'b1, 1'b0);
         tick(1'b0, 1'b0);
      end
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check_eq("sat_loss", int'(loss_cnt), 255);
      check_eq("sat_retry", int'(retry_cnt), 0);

      // Reset during a PLL reset pulse
      if (Auto) begin
         guard = 0;
         while (m_state != 3 && guard < 200) begin
            tick(1'b0, 1'b0);
            guard++;
         end
         check_eq("pulse_reached", int'(guard < 200), 1);
         tick(1'b0, 1'b0);
         check_eq("pulse_active", int'(pll_rst), 1);
      end
      tick(1'b0, 1'b1);
      check_eq("rst_pulse_pll_rst", int'(pll_rst), 0);
      check_eq("rst_pulse_loss", int'(loss_cnt), 0);
      check_eq("rst_pulse_retry", int'(retry_cnt), 0);
      check_eq("rst_pulse_rst_out", int'(rst_out), 1);
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);

      // Reset while in RUN
      for (int k = 0; k < SS + SC + 2; k++) tick(1'b1, 1'b0);
      check_eq("run_before_rst", int'(ready), 1);
      tick(1'b1, 1'b1);
      check_eq("run_rst_ready", int'(ready), 0);
      for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);

      @(negedge sys_clk);
      check_eq("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
